pipe_result_tracker: RTL

Producer side of the operand-forwarding network. It carries each issued instruction's destination register, write-enable, load flag and result down the EX → MEM_REQ → MEM_RESP → WB pipeline registers. It drives the per-stage `rd` / `reg_we` / result buses that the operand selectors compare against `rs1`/`rs2`. It also detects load-use hazards, drives the decode-stage stall, and counts stall cycles.

---
 rtl/pipe_result_tracker.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pipe_result_tracker.sv
// Destination/result tracking for EX -> MEM_REQ -> MEM_RESP -> WB, feeding the
// operand-forwarding selectors, plus load-use hazard stall generation and counting.
module pipe_result_tracker #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hold_all,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [4:0]      id_rd,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_reg_we,
    input  logic            id_is_load,
    input  logic            id_uses_rs1,
    input  logic            id_uses_rs2,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic [XLEN-1:0] mem_resp_data,
    output logic [4:0]      ex_rd,
    output logic [4:0]      mem_req_rd,
    output logic [4:0]      mem_resp_rd,
    output logic [4:0]      wb_rd,
    output logic            ex_reg_we,
    output logic            mem_req_reg_we,
    output logic            mem_resp_reg_we,
    output logic            wb_reg_we,
    output logic [XLEN-1:0] mem_req_alu_result,
    output logic [XLEN-1:0] mem_resp_alu_result,
    output logic [XLEN-1:0] writeback,
    output logic            stall,
    output logic [31:0]     stall_count
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       we;
        logic       is_load;
    } ctl_t;

    typedef struct packed {
        ctl_t            ctl;
        logic [XLEN-1:0] result;
    } dat_t;

    typedef struct packed {
        logic            valid;
        logic [4:0]      rd;
        logic            we;
        logic [XLEN-1:0] result;
    } wb_t;

    ctl_t        ex_q, ex_d;
    dat_t        mreq_q, mreq_d;
    dat_t        mresp_q, mresp_d;
    wb_t         wb_q, wb_d;
    logic [31:0] cnt_q, cnt_d;
    logic        hazard;

    // A stage blocks decode only while it holds a load whose data is not yet in WB.
    function automatic logic load_match(input ctl_t s);
        return s.valid & s.we & s.is_load &
               ((id_uses_rs1 & (id_rs1 == s.rd)) | (id_uses_rs2 & (id_rs2 == s.rd)));
    endfunction

    always_comb begin
        hazard = id_valid & (load_match(ex_q) | load_match(mreq_q.ctl) | load_match(mresp_q.ctl));
        stall  = hazard & ~flush;
    end

    always_comb begin
        ex_d    = ex_q;
        mreq_d  = mreq_q;
        mresp_d = mresp_q;
        wb_d    = wb_q;
        cnt_d   = cnt_q;
        if (!hold_all) begin
            if (stall || flush) begin
                ex_d = '0;
            end else begin
                ex_d.valid   = id_valid;
                ex_d.rd      = id_rd;
                ex_d.we      = id_valid & id_reg_we & (id_rd != 5'd0);
                ex_d.is_load = id_is_load;
            end
            if (flush) begin
                mreq_d = '0;
            end else begin
                mreq_d.ctl    = ex_q;
                mreq_d.result = ex_alu_result;
            end
            mresp_d     = mreq_q;
            wb_d.valid  = mresp_q.ctl.valid;
            wb_d.rd     = mresp_q.ctl.rd;
            wb_d.we     = mresp_q.ctl.we;
            wb_d.result = mresp_q.ctl.is_load ? mem_resp_data : mresp_q.result;
            cnt_d       = cnt_q + {31'd0, stall};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q    <= '0;
            mreq_q  <= '0;
            mresp_q <= '0;
            wb_q    <= '0;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            mreq_q  <= mreq_d;
            mresp_q <= mresp_d;
            wb_q    <= wb_d;
            cnt_q   <= cnt_d;
        end
    end

    // Loads are only forwardable once their data has reached WB.
    always_comb begin
        ex_rd               = ex_q.rd;
        mem_req_rd          = mreq_q.ctl.rd;
        mem_resp_rd         = mresp_q.ctl.rd;
        wb_rd               = wb_q.rd;
        ex_reg_we           = ex_q.valid & ex_q.we & ~ex_q.is_load;
        mem_req_reg_we      = mreq_q.ctl.valid & mreq_q.ctl.we & ~mreq_q.ctl.is_load;
        mem_resp_reg_we     = mresp_q.ctl.valid & mresp_q.ctl.we & ~mresp_q.ctl.is_load;
        wb_reg_we           = wb_q.valid & wb_q.we;
        mem_req_alu_result  = mreq_q.result;
        mem_resp_alu_result = mresp_q.result;
        writeback           = wb_q.result;
        stall_count         = cnt_q;
    end

endmodule
